maj_fold_sequencer: RTL

//  Folded, multi-cycle evaluator for the N-input majority function.
//  - Accepts one N-bit vector over a valid/ready handshake.
//  - Streams it CHUNK bits per cycle through a small popcount slice into an accumulator.
//  - Returns the majority bit, with early termination as soon as the outcome is fixed.
//  - Sequences the shared majority datapath for a single requester.
//  - Drop-in cycle-level alternative to the flat maj-N netlist, for area/latency studies.

---
 rtl/maj_fold_sequencer.sv | 132 +++++++++++++
 1 files changed

// File: rtl/maj_fold_sequencer.sv
// Folded N-input majority: popcounts CHUNK bits per cycle and stops as soon as the outcome is fixed.
// Latency: out_valid rises 'beats' edges after the accept edge. Backpressure: one vector in flight; result held until out_ready.
module maj_fold_sequencer #(
    parameter int N     = 511,
    parameter int CHUNK = 32,
    localparam int CW     = $clog2(N + 1),
    localparam int NBEATS = (N + CHUNK - 1) / CHUNK,
    localparam int BW     = $clog2(NBEATS + 1),
    localparam int THRESH = (N + 1) / 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_vec,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          y,
    output logic [CW-1:0] count,
    output logic [BW-1:0] beats,
    output logic          early,
    output logic          busy
);

    localparam int PW  = NBEATS * CHUNK;
    localparam int PCW = $clog2(CHUNK + 1);

    if (N % 2 == 0) begin : g_bad_n
        $error("maj_fold_sequencer: N must be odd");
    end
    if (CHUNK < 1 || CHUNK > N) begin : g_bad_chunk
        $error("maj_fold_sequencer: CHUNK must be in 1..N");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Vector is zero-padded to whole chunks and shifted down one chunk per beat,
    // so the current chunk is always the low CHUNK bits.
    logic [PW-1:0]  vec_sh;
    logic [CW-1:0]  acc;
    logic [CW-1:0]  rem;
    logic [BW-1:0]  beat;

    logic [PCW-1:0] pc;
    logic [CW-1:0]  acc_nxt;
    logic [CW-1:0]  rem_nxt;
    logic [CW:0]    reach;
    logic           hit_hi;
    logic           hit_lo;
    logic           decide;

    always_comb begin
        pc = '0;
        for (int i = 0; i < CHUNK; i++) begin
            pc = pc + PCW'(vec_sh[i]);
        end
        acc_nxt = acc + CW'(pc);
        rem_nxt = (rem > CW'(CHUNK)) ? rem - CW'(CHUNK) : '0;
        reach   = {1'b0, acc_nxt} + {1'b0, rem_nxt};
        hit_hi  = acc_nxt >= CW'(THRESH);
        // Even if every unseen bit were 1 the threshold is out of reach.
        hit_lo  = reach < (CW + 1)'(THRESH);
        decide  = hit_hi || hit_lo;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (in_valid) state_nxt = RUN;
            RUN:     if (decide) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vec_sh <= '0;
            acc    <= '0;
            rem    <= '0;
            beat   <= '0;
            y      <= 1'b0;
            count  <= '0;
            beats  <= '0;
            early  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        vec_sh <= PW'(in_vec);
                        acc    <= '0;
                        rem    <= CW'(N);
                        beat   <= '0;
                    end
                end
                RUN: begin
                    if (decide) begin
                        y     <= hit_hi;
                        count <= acc_nxt;
                        beats <= beat + BW'(1);
                        early <= (beat + BW'(1)) < BW'(NBEATS);
                    end else begin
                        acc    <= acc_nxt;
                        rem    <= rem_nxt;
                        beat   <= beat + BW'(1);
                        vec_sh <= vec_sh >> CHUNK;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

endmodule
